universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   Parametrised universal shift register: hold/shift/rotate/arith-shift/load/clear,
//   plus a burst engine that performs N shifts autonomously with busy/done handshake.
//   Next-generation replacement for the chained fixed 8-bit shift-register stages;
//   used as the serialiser/deserialiser and barrel-lite shifter in the datapath.
// PARAMETERS
//   WIDTH      32   register width in bits (>=2)
//   RESET_VAL  0    value loaded into the register on reset (WIDTH bits)
//   CNT_W      $clog2(WIDTH)+1 (localparam)  width of burst count, holds 0..WIDTH
// PORTS
//   clk     in   1        rising-edge clock
//   reset   in   1        asynchronous, active-low reset
//   mode    in   3        operation select (table below)
//   sin     in   1        serial input bit
//   p_in    in   WIDTH    parallel load data
//   start   in   1        burst request (IDLE only)
//   count   in   CNT_W    burst length in shifts, sampled with start
//   sout    out  1        serial output = bit leaving on the next shift
//   status  out  WIDTH    current register contents
//   busy    out  1        high while burst in progress
//   done    out  1        one-cycle pulse when burst completes
//   parity  out  1        XOR of status (only with USR_PARITY_EN)
// BEHAVIOUR
//   mode: 000 hold | 001 SRL: {sin,q[W-1:1]} | 010 SLL: {q[W-2:0],sin}
//         011 load p_in | 100 ROR | 101 ROL | 110 SRA: {q[W-1],q[W-1:1]} | 111 clear to 0
//   Reset (reset=0, async): q=RESET_VAL, state=IDLE, busy=0, done=0, count latch=0.
//   Reset mid-burst aborts immediately; no done pulse issued.
//   FSM states IDLE, RUN.
//   IDLE: mode applied every rising edge. If start=1 AND count!=0 AND mode in
//     {001,010,100,101,110}: latch mode and count, go RUN; no shift on that edge.
//     start with count=0 or mode in {000,011,111}: ignored, mode applied as normal.
//   RUN: one shift per edge using latched mode; mode, p_in, start ignored; sin
//     sampled every edge. Remaining counter decrements per shift.
//     After the count-th shift (edge k+count, start seen at edge k) -> IDLE.
//   busy: registered, high for exactly count cycles (after edge k to edge k+count).
//   done: registered, high for the one cycle after edge k+count; 0 otherwise.
//   start while busy: ignored, not queued. Back-to-back: start in the cycle done=1
//     (now IDLE) is accepted.
//   count > WIDTH: saturated to WIDTH before latching.
//   sout: combinational; q[W-1] when active direction is left (010,101),
//     else q[0]. Active direction = latched mode in RUN, mode input in IDLE.
//   No output depends combinationally on start or count.
// CONFIGURATION
//   USR_PARITY_EN defined: parity port present, registered, = ^q_next; updated
//     every edge q changes; reset value = ^RESET_VAL.
//   Not defined: parity port and logic absent; all other behaviour identical.
// TESTING
//   reset=0 during activity with RESET_VAL=32'hA5A5_0000 -> status=A5A5_0000, busy=0, done=0 at once
//   mode=011 p_in=32'h8000_0001, then mode=100 one edge -> status=C000_0000, sout was 1
//   load 32'h8000_0000, mode=110, 4 hold edges of SRA -> status=F800_0000
//   load 32'h0000_00FF, start mode=010 count=8 sin=0 -> busy 8 cycles, done 1 cycle,
//     status=0000_FF00, sout sequence 0 x8; start during busy ignored
//   start with count=0 or mode=011 -> busy stays 0, no done; count=40 -> 32 shifts
//   reset low at cycle 3 of count=8 burst -> busy=0, no done, status=RESET_VAL;
//     USR_PARITY_EN build: load 32'h0000_0007 -> parity=1, ROL x1 -> parity=1

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register with an autonomous N-shift burst engine (busy/done handshake).
// Optional registered parity output when USR_PARITY_EN is defined.
module universal_shift_register #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             sout,
  output logic [WIDTH-1:0] status,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SRL  = 3'b001;
  localparam logic [2:0] M_SLL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_SRA  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       act_mode_c;
  logic [CNT_W-1:0] cnt_sat_c;
  logic             burst_ok_c;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v,
                                                input logic s,
                                                input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      M_HOLD: r = v;
      M_SRL:  r = {s, v[WIDTH-1:1]};
      M_SLL:  r = {v[WIDTH-2:0], s};
      M_LOAD: r = ld;
      M_ROR:  r = {v[0], v[WIDTH-1:1]};
      M_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only genuine shift/rotate modes may run as a burst.
  assign burst_ok_c = start && (count != '0) &&
                      (mode inside {M_SRL, M_SLL, M_ROR, M_ROL, M_SRA});
  assign cnt_sat_c  = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_ok_c) begin
          mode_d  = mode;
          cnt_d   = cnt_sat_c;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          q_d = apply_op(mode, q_q, sin, p_in);
        end
      end
      RUN: begin
        q_d   = apply_op(mode_q, q_q, sin, p_in);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Serial out is the bit that leaves on the next shift in the active direction.
  assign act_mode_c = (state_q == RUN) ? mode_q : mode;
  assign sout       = ((act_mode_c == M_SLL) || (act_mode_c == M_ROL)) ? q_q[WIDTH-1] : q_q[0];

  assign status = q_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef USR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_q <= ^RESET_VAL;
    else        parity_q <= ^q_d;
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised self-checking bench for universal_shift_register against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [W-1:0] RV = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic          sin;
  logic [W-1:0]  p_in;
  logic          start;
  logic [CW-1:0] count;
  logic          sout;
  logic [W-1:0]  status;
  logic          busy;
  logic          done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_q;
  int           m_rem;
  logic [2:0]   m_bmode;
  logic         m_busy;
  logic         m_done;

  universal_shift_register #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .sin    (sin),
    .p_in   (p_in),
    .start  (start),
    .count  (count),
    .sout   (sout),
    .status (status),
    .busy   (busy),
    .done   (done)
`ifdef USR_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] v,
                                          input logic s, input logic [W-1:0] ld);
    case (op)
      3'd0: return v;
      3'd1: return (v >> 1) | (W'(s) << (W - 1));
      3'd2: return (v << 1) | W'(s);
      3'd3: return ld;
      3'd4: return (v >> 1) | (v << (W - 1));
      3'd5: return (v << 1) | (v >> (W - 1));
      3'd6: return W'($signed(v) >>> 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_sout();
    logic [2:0] am;
    am = (m_rem > 0) ? m_bmode : mode;
    return (am == 3'd2 || am == 3'd5) ? m_q[W-1] : m_q[0];
  endfunction

  task automatic model_reset();
    m_q = RV; m_rem = 0; m_bmode = 3'd0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    int c;
    if (m_rem == 0) begin
      m_done = 1'b0;
      if (start && count != 0 && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        c = int'(count);
        m_rem   = (c > int'(W)) ? int'(W) : c;
        m_bmode = mode;
        m_busy  = 1'b1;
      end else begin
        m_q    = ref_op(mode, m_q, sin, p_in);
        m_busy = 1'b0;
      end
    end else begin
      m_q    = ref_op(m_bmode, m_q, sin, p_in);
      m_rem  = m_rem - 1;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_status"}, status, m_q);
    check({tag, "_busy"}, W'(busy), W'(m_busy));
    check({tag, "_done"}, W'(done), W'(m_done));
`ifdef USR_PARITY_EN
    check({tag, "_parity"}, W'(parity), W'(^m_q));
`endif
  endtask

  // Inputs are already driven; check sout, take one edge, check registered outputs.
  task automatic tick(input string tag);
    #1;
    check({tag, "_sout"}, W'(sout), W'(ref_sout()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic [2:0] m, input logic s, input logic [W-1:0] p,
                       input logic st, input logic [CW-1:0] c);
    mode = m; sin = s; p_in = p; start = st; count = c;
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    drive(3'd0, 1'b0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    check("rst_const", status, 32'hA5A5_0000);
    reset = 1'b1;

    // Load then one rotate right
    drive(3'd3, 1'b0, 32'h8000_0001, 1'b0, '0);
    tick("load1");
    drive(3'd4, 1'b0, '0, 1'b0, '0);
    #1;
    check("ror_sout", W'(sout), 32'd1);
    tick("ror");
    check("ror_const", status, 32'hC000_0000);

    // Arithmetic right shift x4
    drive(3'd3, 1'b0, 32'h8000_0000, 1'b0, '0);
    tick("load2");
    for (int i = 0; i < 4; i++) begin
      drive(3'd6, 1'b1, '0, 1'b0, '0);
      tick("sra");
    end
    check("sra_const", status, 32'hF800_0000);

    // Left-shift burst of 8 with ignored start requests while busy
    drive(3'd3, 1'b0, 32'h0000_00FF, 1'b0, '0);
    tick("load3");
    drive(3'd2, 1'b0, '0, 1'b1, 6'd8);
    tick("bst_start");
    check("bst_busy_hi", W'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(3'($urandom_range(0, 7)), 1'b0, $urandom, 1'b1, 6'($urandom_range(1, 40)));
      tick("bst_run");
    end
    check("bst_const", status, 32'h0000_FF00);
    check("bst_done", W'(done), 32'd1);
    check("bst_busy_lo", W'(busy), 32'd0);
    // Back-to-back start in the done cycle
    drive(3'd1, 1'b1, '0, 1'b1, 6'd1);
    tick("b2b_start");
    check("b2b_busy", W'(busy), 32'd1);
    drive(3'd0, 1'b0, '0, 1'b0, '0);
    tick("b2b_end");

    // Ignored starts
    drive(3'd2, 1'b1, '0, 1'b1, 6'd0);
    tick("cnt0");
    check("cnt0_busy", W'(busy), 32'd0);
    drive(3'd3, 1'b1, 32'h1234_5678, 1'b1, 6'd5);
    tick("ldstart");
    check("ldstart_busy", W'(busy), 32'd0);

    // Saturated count
    drive(3'd4, 1'b0, '0, 1'b1, 6'd40);
    tick("sat_start");
    drive(3'd0, 1'b0, '0, 1'b0, '0);
    n = 0;
    while (busy && n < 50) begin
      tick("sat_run");
      n++;
    end
    check("sat_shifts", W'(n), 32'd32);
    check("sat_val", status, 32'h1234_5678);

    // Reset in the middle of a burst
    drive(3'd3, 1'b0, 32'h0F0F_0F0F, 1'b0, '0);
    tick("load4");
    drive(3'd2, 1'b1, '0, 1'b1, 6'd8);
    tick("mid_start");
    drive(3'd0, 1'b1, '0, 1'b0, '0);
    tick("mid_run");
    tick("mid_run");
    async_reset("mid_rst");
    check("mid_rst_const", status, 32'hA5A5_0000);
    tick("mid_after");
    check("mid_no_done", W'(done), 32'd0);

`ifdef USR_PARITY_EN
    drive(3'd3, 1'b0, 32'h0000_0007, 1'b0, '0);
    tick("par_load");
    check("par_load_const", W'(parity), 32'd1);
    drive(3'd5, 1'b0, '0, 1'b0, '0);
    tick("par_rol");
    check("par_rol_const", W'(parity), 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 40)));
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
